// File: rtl/regfile_access_sequencer.sv
// regfile_access_sequencer: drives operand reads, the ALU handshake and result write-back on the register-file port
module regfile_access_sequencer #(
   parameter int WORD_BITS = 32,
   parameter int ADDR_BITS = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ADDR_BITS-1:0] req_ra,
   input  logic [ADDR_BITS-1:0] req_rb,
   input  logic [ADDR_BITS-1:0] req_rc,
   input  logic                 req_wb,
   output logic                 op_valid,
   input  logic                 op_ready,
   output logic [WORD_BITS-1:0] op_a,
   output logic [WORD_BITS-1:0] op_b,
   input  logic                 res_valid,
   output logic                 res_ready,
   input  logic [WORD_BITS-1:0] res_data,
   output logic [ADDR_BITS-1:0] rf_out_a,
   output logic [ADDR_BITS-1:0] rf_out_b,
   output logic [ADDR_BITS-1:0] rf_in_c,
   output logic [WORD_BITS-1:0] rf_e,
   output logic                 rf_enable,
   output logic                 rf_updateB,
   input  logic [WORD_BITS-1:0] rf_a,
   input  logic [WORD_BITS-1:0] rf_b,
   output logic                 timeout_err
);
   typedef enum logic [2:0] {IDLE, RD_STB, RD_CAP, OFFER, WAIT_RES, WR_STB, WR_HOLD} state_t;
   state_t               state_q, state_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] rc_q, rc_d, rf_out_a_q, rf_out_a_d, rf_out_b_q, rf_out_b_d, rf_in_c_q, rf_in_c_d;
   logic [WORD_BITS-1:0] op_a_q, op_a_d, op_b_q, op_b_d, rf_e_q, rf_e_d;
   logic                 wb_q, wb_d, req_ready_q, req_ready_d, op_valid_q, op_valid_d, res_ready_q, res_ready_d;
   logic                 rf_enable_q, rf_enable_d, rf_update_b_q, rf_update_b_d, timeout_err_q, timeout_err_d;
   logic                 accept, to_hit;
   // next state plus next value of every registered output, derived from where the FSM is heading
   always_comb begin
      accept = req_valid & req_ready_q;
      state_d = state_q;
      cnt_d = cnt_q;
      to_hit = 1'b0;
      case (state_q)
         IDLE:     if (accept) state_d = RD_STB;
         RD_STB:   state_d = RD_CAP;
         RD_CAP:   state_d = OFFER;
         OFFER: begin
            if (op_ready) state_d = wb_q ? WAIT_RES : IDLE;
            cnt_d = '0;
         end
         WAIT_RES: begin
            if (res_valid) state_d = WR_STB;
            else if (cnt_q == 8'(TIMEOUT - 1)) begin
               state_d = IDLE;
               to_hit = 1'b1;
            end else cnt_d = cnt_q + 8'd1;
         end
         WR_STB:   state_d = WR_HOLD;
         WR_HOLD:  state_d = IDLE;
         default:  state_d = IDLE;
      endcase
      rc_d = accept ? req_rc : rc_q;
      wb_d = accept ? req_wb : wb_q;
      rf_out_a_d = accept ? req_ra : rf_out_a_q;
      rf_out_b_d = accept ? req_rb : rf_out_b_q;
      op_a_d = (state_q == RD_CAP) ? rf_a : op_a_q;
      op_b_d = (state_q == RD_CAP) ? rf_b : op_b_q;
      rf_e_d = (state_q == WAIT_RES && res_valid) ? res_data : rf_e_q;
      rf_in_c_d = (state_d == WR_STB) ? rc_q : rf_in_c_q;
      req_ready_d = state_d == IDLE;
      op_valid_d = state_d == OFFER;
      res_ready_d = state_d == WAIT_RES;
      rf_enable_d = state_d == WR_STB || state_d == WR_HOLD;
      rf_update_b_d = state_d == RD_STB || state_d == WR_STB;
      timeout_err_d = timeout_err_q | to_hit;
   end
   // all state and outputs registered; reset aborts any operation immediately
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         rc_q <= '0;
         wb_q <= 1'b0;
         rf_out_a_q <= '0;
         rf_out_b_q <= '0;
         rf_in_c_q <= '0;
         op_a_q <= '0;
         op_b_q <= '0;
         rf_e_q <= '0;
         req_ready_q <= 1'b0;
         op_valid_q <= 1'b0;
         res_ready_q <= 1'b0;
         rf_enable_q <= 1'b0;
         rf_update_b_q <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         rc_q <= rc_d;
         wb_q <= wb_d;
         rf_out_a_q <= rf_out_a_d;
         rf_out_b_q <= rf_out_b_d;
         rf_in_c_q <= rf_in_c_d;
         op_a_q <= op_a_d;
         op_b_q <= op_b_d;
         rf_e_q <= rf_e_d;
         req_ready_q <= req_ready_d;
         op_valid_q <= op_valid_d;
         res_ready_q <= res_ready_d;
         rf_enable_q <= rf_enable_d;
         rf_update_b_q <= rf_update_b_d;
         timeout_err_q <= timeout_err_d;
      end
   end
   assign req_ready = req_ready_q;
   assign op_valid = op_valid_q;
   assign op_a = op_a_q;
   assign op_b = op_b_q;
   assign res_ready = res_ready_q;
   assign rf_out_a = rf_out_a_q;
   assign rf_out_b = rf_out_b_q;
   assign rf_in_c = rf_in_c_q;
   assign rf_e = rf_e_q;
   assign rf_enable = rf_enable_q;
   assign rf_updateB = rf_update_b_q;
   assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_regfile_access_sequencer.sv
// tb_regfile_access_sequencer: random and directed instructions checked against a register-array model
module tb_regfile_access_sequencer;
   localparam int TO = 4;
   logic clock = 1'b0, reset = 1'b1, init = 1'b1;
   logic req_valid, req_ready, req_wb, op_valid, op_ready, res_valid, res_ready;
   logic rf_enable, rf_updateB, timeout_err;
   logic [3:0] req_ra, req_rb, req_rc, rf_out_a, rf_out_b, rf_in_c;
   logic [31:0] op_a, op_b, res_data, rf_e, rf_a, rf_b;
   logic [31:0] regs [16];
   logic [31:0] exp_regs [16];
   int checks = 0, fails = 0, upd_n = 0, en_n = 0;
   logic [3:0] last_c;
   logic [31:0] last_e;

   always #5 clock = ~clock;

   regfile_access_sequencer #(.WORD_BITS(32), .ADDR_BITS(4), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_ra(req_ra), .req_rb(req_rb), .req_rc(req_rc), .req_wb(req_wb),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .rf_out_a(rf_out_a), .rf_out_b(rf_out_b), .rf_in_c(rf_in_c), .rf_e(rf_e),
      .rf_enable(rf_enable), .rf_updateB(rf_updateB), .rf_a(rf_a), .rf_b(rf_b),
      .timeout_err(timeout_err));

   // register file: combinational read, write on every edge while enabled
   assign rf_a = regs[rf_out_a];
   assign rf_b = regs[rf_out_b];
   always @(posedge clock) begin
      if (init) for (int i = 0; i < 16; i++) regs[i] <= 32'(i) * 32'h11;
      else if (rf_enable) regs[rf_in_c] <= rf_e;
   end

   // running strobe counters and last write seen
   always @(negedge clock) begin
      if (rf_updateB) upd_n++;
      if (rf_enable) begin
         en_n++;
         last_c = rf_in_c;
         last_e = rf_e;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time expired");
      $fatal(1);
   end

   function automatic logic [113:0] outs();
      return {req_ready, op_valid, op_a, op_b, res_ready, rf_out_a, rf_out_b, rf_in_c, rf_e, rf_enable, rf_updateB, timeout_err};
   endfunction

   task automatic do_instr(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc, input logic wb,
                           input logic [31:0] res, input int op_wait, input int res_wait, input bit abort,
                           output logic [31:0] a, output logic [31:0] b, output int lat, output int post, output bit stable);
      int n;
      req_ra = ra; req_rb = rb; req_rc = rc; req_wb = wb; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clock); n++; end
      @(negedge clock);
      req_valid = 1'b0;
      lat = 1;
      while (!op_valid && lat < 20) begin @(negedge clock); lat++; end
      a = op_a; b = op_b; stable = 1'b1;
      repeat (op_wait) begin
         @(negedge clock);
         if (!op_valid || req_ready || op_a !== a || op_b !== b) stable = 1'b0;
      end
      op_ready = 1'b1;
      @(negedge clock);
      op_ready = 1'b0;
      post = 0;
      if (wb && res_wait < 0) begin
         n = 0;
         while (!req_ready && n < 30) begin
            if (res_ready) post++;
            @(negedge clock);
            n++;
         end
         return;
      end
      if (wb) begin
         repeat (res_wait) @(negedge clock);
         res_data = res; res_valid = 1'b1;
         @(negedge clock);
         res_valid = 1'b0;
         if (abort) begin
            reset = 1'b1;
            #1;
            post = int'(|outs());
            return;
         end
      end
      post = 1;
      while (!req_ready && post < 20) begin @(negedge clock); post++; end
   endtask

   task automatic test_reset();
      reset = 1'b1; init = 1'b1;
      req_valid = 0; req_ra = 0; req_rb = 0; req_rc = 0; req_wb = 0;
      op_ready = 0; res_valid = 0; res_data = 0;
      repeat (3) @(negedge clock);
      checks++;
      if (outs() !== '0) begin fails++; $display("FAIL reset_outputs: got %h expected 0", outs()); end
      init = 1'b0; reset = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_before_clock: got %b expected 0", req_ready); end
      @(negedge clock);
      checks++;
      if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after_clock: got %b expected 1", req_ready); end
      for (int i = 0; i < 16; i++) exp_regs[i] = 32'(i) * 32'h11;
   endtask

   task automatic test_read_only();
      logic [31:0] a, b; int lat, post, u0, e0; bit st;
      u0 = upd_n; e0 = en_n;
      do_instr(4'd1, 4'd2, 4'd0, 1'b0, 32'h0, 0, 0, 1'b0, a, b, lat, post, st);
      checks++; if (a !== 32'h11) begin fails++; $display("FAIL rd_op_a: got %h expected 11", a); end
      checks++; if (b !== 32'h22) begin fails++; $display("FAIL rd_op_b: got %h expected 22", b); end
      checks++; if (lat !== 3) begin fails++; $display("FAIL rd_latency: got %0d expected 3", lat); end
      checks++; if (upd_n - u0 !== 1) begin fails++; $display("FAIL rd_updateb_pulses: got %0d expected 1", upd_n - u0); end
      checks++; if (en_n - e0 !== 0) begin fails++; $display("FAIL rd_enable_cycles: got %0d expected 0", en_n - e0); end
   endtask

   task automatic test_write();
      logic [31:0] a, b; int lat, post, u0, e0; bit st;
      u0 = upd_n; e0 = en_n;
      do_instr(4'd3, 4'd4, 4'd5, 1'b1, 32'hDEADBEEF, 0, 1, 1'b0, a, b, lat, post, st);
      checks++; if (a !== exp_regs[3] || b !== exp_regs[4]) begin fails++; $display("FAIL wr_operands: got %h %h expected %h %h", a, b, exp_regs[3], exp_regs[4]); end
      checks++; if (post !== 3) begin fails++; $display("FAIL wr_latency: got %0d expected 3", post); end
      checks++; if (en_n - e0 !== 2) begin fails++; $display("FAIL wr_enable_cycles: got %0d expected 2", en_n - e0); end
      checks++; if (upd_n - u0 !== 2) begin fails++; $display("FAIL wr_updateb_pulses: got %0d expected 2", upd_n - u0); end
      checks++; if (last_c !== 4'd5 || last_e !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_addr_data: got %0d %h expected 5 deadbeef", last_c, last_e); end
      exp_regs[5] = 32'hDEADBEEF;
      checks++; if (regs[5] !== exp_regs[5]) begin fails++; $display("FAIL wr_regfile: got %h expected %h", regs[5], exp_regs[5]); end
   endtask

   task automatic test_stall();
      logic [31:0] a, b; int lat, post; bit st; logic [3:0] ra, rb;
      ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
      do_instr(ra, rb, 4'd0, 1'b0, 32'h0, 10, 0, 1'b0, a, b, lat, post, st);
      checks++; if (st !== 1'b1) begin fails++; $display("FAIL stall_stable: got %b expected 1", st); end
      checks++; if (a !== exp_regs[ra] || b !== exp_regs[rb]) begin fails++; $display("FAIL stall_operands: got %h %h expected %h %h", a, b, exp_regs[ra], exp_regs[rb]); end
   endtask

   task automatic test_timeout_boundary();
      logic [31:0] a, b, r; int lat, post; bit st; logic [3:0] rc;
      rc = 4'($urandom_range(8, 15)); r = $urandom;
      do_instr(4'd0, 4'd1, rc, 1'b1, r, 0, TO - 1, 1'b0, a, b, lat, post, st);
      exp_regs[rc] = r;
      checks++; if (post !== 3) begin fails++; $display("FAIL late_res_latency: got %0d expected 3", post); end
      checks++; if (regs[rc] !== exp_regs[rc]) begin fails++; $display("FAIL late_res_write: got %h expected %h", regs[rc], exp_regs[rc]); end
      checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL late_res_err: got %b expected 0", timeout_err); end
   endtask

   task automatic test_timeout();
      logic [31:0] a, b; int lat, post, e0; bit st; logic [3:0] rc, ra, rb;
      rc = 4'($urandom_range(0, 15)); e0 = en_n;
      do_instr(4'd2, 4'd3, rc, 1'b1, $urandom, 0, -1, 1'b0, a, b, lat, post, st);
      checks++; if (post !== TO) begin fails++; $display("FAIL timeout_wait_cycles: got %0d expected %0d", post, TO); end
      checks++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_err_set: got %b expected 1", timeout_err); end
      checks++; if (en_n - e0 !== 0) begin fails++; $display("FAIL timeout_no_write: got %0d expected 0", en_n - e0); end
      checks++; if (regs[rc] !== exp_regs[rc]) begin fails++; $display("FAIL timeout_regfile: got %h expected %h", regs[rc], exp_regs[rc]); end
      ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
      do_instr(ra, rb, 4'd0, 1'b0, 32'h0, 1, 0, 1'b0, a, b, lat, post, st);
      checks++; if (a !== exp_regs[ra] || b !== exp_regs[rb] || lat !== 3) begin fails++; $display("FAIL after_timeout: got %h %h lat %0d expected %h %h lat 3", a, b, lat, exp_regs[ra], exp_regs[rb]); end
      checks++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_err_sticky: got %b expected 1", timeout_err); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] a, b; int lat, post; bit st; logic [3:0] rc;
      rc = 4'($urandom_range(0, 15));
      do_instr(4'd1, 4'd2, rc, 1'b1, ~exp_regs[rc], 0, 0, 1'b1, a, b, lat, post, st);
      checks++; if (post !== 0) begin fails++; $display("FAIL abort_outputs: got %0d expected 0", post); end
      repeat (2) @(negedge clock);
      checks++; if (regs[rc] !== exp_regs[rc]) begin fails++; $display("FAIL abort_no_write: got %h expected %h", regs[rc], exp_regs[rc]); end
      reset = 1'b0;
      @(negedge clock);
      checks++; if (req_ready !== 1'b1 || timeout_err !== 1'b0) begin fails++; $display("FAIL abort_recover: got ready %b err %b expected 1 0", req_ready, timeout_err); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, r; int lat, post; bit st; logic [3:0] ra, rb, rc; logic wb;
      r = $urandom;
      do_instr(4'd1, 4'd2, 4'd7, 1'b1, r, 0, 0, 1'b0, a, b, lat, post, st);
      exp_regs[7] = r;
      do_instr(4'd7, 4'd7, 4'd0, 1'b0, 32'h0, 0, 0, 1'b0, a, b, lat, post, st);
      checks++; if (a !== r || b !== r) begin fails++; $display("FAIL b2b_forward: got %h %h expected %h", a, b, r); end
      for (int i = 0; i < 24; i++) begin
         ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15)); rc = 4'($urandom_range(0, 15));
         wb = 1'($urandom_range(0, 1)); r = $urandom;
         do_instr(ra, rb, rc, wb, r, $urandom_range(0, 3), $urandom_range(0, TO - 1), 1'b0, a, b, lat, post, st);
         checks++;
         if (a !== exp_regs[ra] || b !== exp_regs[rb] || lat !== 3 || (wb && post !== 3)) begin
            fails++;
            $display("FAIL rand_instr %0d: got %h %h lat %0d post %0d expected %h %h lat 3 post 3", i, a, b, lat, post, exp_regs[ra], exp_regs[rb]);
         end
         if (wb) exp_regs[rc] = r;
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (regs[i] !== exp_regs[i]) begin fails++; $display("FAIL final_reg %0d: got %h expected %h", i, regs[i], exp_regs[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_read_only();
      test_write();
      test_stall();
      test_timeout_boundary();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
